// File: rtl/lcd_pkg.sv
// Shared command/state encodings and init-sequence table for the LCD command sequencer.
package lcd_pkg;

  localparam int N_CMD = 8;

  // Enum value doubles as the strobe bit index.
  typedef enum logic [2:0] {
    CMD_RESET, CMD_SET, CMD_CLEAR, CMD_OFF, CMD_ON, CMD_ENTRY, CMD_CURSOR, CMD_WCHAR
  } cmd_e;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_GAP, S_ISSUE, S_ACK, S_DONE, S_READY
  } state_e;

  localparam cmd_e INIT_STEPS [8] = '{
    CMD_RESET, CMD_RESET, CMD_RESET, CMD_SET, CMD_OFF, CMD_CLEAR, CMD_ENTRY, CMD_ON
  };

  localparam logic [6:0] DDRAM_LINE0 = 7'h00;
  localparam logic [6:0] DDRAM_LINE1 = 7'h40;

  function automatic logic [N_CMD-1:0] cmd_onehot(input cmd_e c);
    return N_CMD'(1) << c;
  endfunction

endpackage

// File: rtl/lcd_cmd_handshake.sv
// Issue/ack/done handshake with the LCD engine: one strobe per request, ack timeout.
module lcd_cmd_handshake
  import lcd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_idle_i,
  input  logic             req_i,
  input  logic [N_CMD-1:0] cmd_i,
  output logic [N_CMD-1:0] strobe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e           state_q;
  logic [TW-1:0]    tmr_q;
  logic [N_CMD-1:0] strobe_q;
  logic             ack_expired;

  assign ack_expired = (state_q == S_ACK) && lcd_idle_i && (tmr_q == TW'(ACK_TIMEOUT - 1));
  // Done is combinational so the requester moves on in the same edge we return to S_ISSUE.
  assign done_o    = ack_expired || ((state_q == S_DONE) && lcd_idle_i);
  assign timeout_o = ack_expired;
  assign busy_o    = (state_q != S_ISSUE);
  assign strobe_o  = strobe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ISSUE;
      tmr_q    <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      case (state_q)
        S_ISSUE: if (req_i && lcd_idle_i) begin
          strobe_q <= cmd_i;
          tmr_q    <= '0;
          state_q  <= S_ACK;
        end
        S_ACK: begin
          if (!lcd_idle_i)     state_q <= S_DONE;
          else if (ack_expired) state_q <= S_ISSUE;
          else                 tmr_q   <= tmr_q + TW'(1);
        end
        S_DONE: if (lcd_idle_i) state_q <= S_ISSUE;
        default: state_q <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD master sequencer: HD44780 power-up init, character stream with lazy line wrap, clears.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES   = 1500000,
  parameter int RST_GAP_CYCLES = 410000,
  parameter int ACK_TIMEOUT    = 16,
  parameter int LINE_LEN       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_idle,
  output logic       cmd_reset,
  output logic       cmd_set,
  output logic       cmd_clear,
  output logic       cmd_off,
  output logic       cmd_on,
  output logic       cmd_entry,
  output logic       cmd_cursor,
  output logic       cmd_wchar,
  output logic [7:0] char_data,
  output logic [6:0] cursor_addr,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clr_req,
  output logic       clr_ack,
  output logic       init_done,
  output logic       line,
  output logic [4:0] col,
  output logic       err
);

  localparam int DMAX = (PWRUP_CYCLES > RST_GAP_CYCLES) ? PWRUP_CYCLES : RST_GAP_CYCLES;
  localparam int CW   = $clog2(DMAX + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       step_q;
  cmd_e             cmd_q;
  logic [7:0]       char_q;
  logic [6:0]       addr_q;
  logic             clr_ack_q, init_done_q, line_q, err_q;
  logic [4:0]       col_q;

  logic             hs_req, hs_busy, hs_done, hs_timeout;
  logic [N_CMD-1:0] hs_cmd, hs_strobe;

  assign hs_req = ((state_q == S_INIT) || (state_q == S_ISSUE)) && !hs_busy;
  assign hs_cmd = cmd_onehot((state_q == S_INIT) ? INIT_STEPS[step_q] : cmd_q);

  lcd_cmd_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs (
    .clk       (clk),
    .rst       (rst),
    .lcd_idle_i(lcd_idle),
    .req_i     (hs_req),
    .cmd_i     (hs_cmd),
    .strobe_o  (hs_strobe),
    .busy_o    (hs_busy),
    .done_o    (hs_done),
    .timeout_o (hs_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      step_q      <= '0;
      cmd_q       <= CMD_RESET;
      char_q      <= '0;
      addr_q      <= '0;
      clr_ack_q   <= 1'b0;
      init_done_q <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      clr_ack_q <= 1'b0;
      if (hs_timeout) err_q <= 1'b1;
      case (state_q)
        S_PWRUP: begin
          if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_INIT;
          end else cnt_q <= cnt_q + CW'(1);
        end
        S_INIT: if (hs_done) begin
          step_q <= step_q + 3'd1;
          if (INIT_STEPS[step_q] == CMD_RESET) state_q <= S_GAP;
          else if (step_q == 3'd7) begin
            init_done_q <= 1'b1;
            line_q      <= 1'b0;
            col_q       <= '0;
            state_q     <= S_READY;
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(RST_GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_INIT;
          end else cnt_q <= cnt_q + CW'(1);
        end
        S_READY: begin
          if (clr_req) begin
            cmd_q   <= CMD_CLEAR;
            state_q <= S_ISSUE;
          end else if (wr_valid) begin
            char_q  <= wr_char;
            state_q <= S_ISSUE;
            // Wrap lazily: the cursor move is only paid for when a char lands past the end.
            if (col_q == 5'(LINE_LEN)) begin
              cmd_q  <= CMD_CURSOR;
              addr_q <= line_q ? DDRAM_LINE0 : DDRAM_LINE1;
            end else cmd_q <= CMD_WCHAR;
          end
        end
        S_ISSUE: if (hs_done) begin
          case (cmd_q)
            CMD_CLEAR: begin
              line_q    <= 1'b0;
              col_q     <= '0;
              clr_ack_q <= 1'b1;
              state_q   <= S_READY;
            end
            CMD_CURSOR: begin
              line_q <= ~line_q;
              col_q  <= '0;
              cmd_q  <= CMD_WCHAR;
            end
            default: begin
              col_q   <= col_q + 5'd1;
              state_q <= S_READY;
            end
          endcase
        end
        default: state_q <= S_PWRUP;
      endcase
    end
  end

  assign cmd_reset   = hs_strobe[CMD_RESET];
  assign cmd_set     = hs_strobe[CMD_SET];
  assign cmd_clear   = hs_strobe[CMD_CLEAR];
  assign cmd_off     = hs_strobe[CMD_OFF];
  assign cmd_on      = hs_strobe[CMD_ON];
  assign cmd_entry   = hs_strobe[CMD_ENTRY];
  assign cmd_cursor  = hs_strobe[CMD_CURSOR];
  assign cmd_wchar   = hs_strobe[CMD_WCHAR];
  assign char_data   = char_q;
  assign cursor_addr = addr_q;
  assign wr_ready    = (state_q == S_READY) && !clr_req;
  assign clr_ack     = clr_ack_q;
  assign init_done   = init_done_q;
  assign line        = line_q;
  assign col         = col_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized bench for lcd_cmd_sequencer: engine model plus expected-command scoreboard.
module tb_lcd_cmd_sequencer;

  localparam int PWRUP = 20, GAP = 5, ACKTO = 16, LL = 16;
  localparam int C_RESET = 0, C_SET = 1, C_CLEAR = 2, C_OFF = 3, C_ON = 4,
                 C_ENTRY = 5, C_CURSOR = 6, C_WCHAR = 7;
  localparam int INIT_SEQ [8] = '{C_RESET, C_RESET, C_RESET, C_SET, C_OFF, C_CLEAR, C_ENTRY, C_ON};

  logic       clk = 1'b0, rst = 1'b1, lcd_idle = 1'b1;
  logic       cmd_reset, cmd_set, cmd_clear, cmd_off, cmd_on, cmd_entry, cmd_cursor, cmd_wchar;
  logic [7:0] char_data;
  logic [6:0] cursor_addr;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       wr_ready;
  logic       clr_req = 1'b0;
  logic       clr_ack, init_done, line, err;
  logic [4:0] col;
  logic [7:0] stb;

  assign stb = {cmd_wchar, cmd_cursor, cmd_entry, cmd_on, cmd_off, cmd_clear, cmd_set, cmd_reset};

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(.PWRUP_CYCLES(PWRUP), .RST_GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKTO), .LINE_LEN(LL)) dut (
    .clk(clk), .rst(rst), .lcd_idle(lcd_idle),
    .cmd_reset(cmd_reset), .cmd_set(cmd_set), .cmd_clear(cmd_clear), .cmd_off(cmd_off),
    .cmd_on(cmd_on), .cmd_entry(cmd_entry), .cmd_cursor(cmd_cursor), .cmd_wchar(cmd_wchar),
    .char_data(char_data), .cursor_addr(cursor_addr),
    .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_ack(clr_ack), .init_done(init_done),
    .line(line), .col(col), .err(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Engine: drops idle for a few cycles after seeing a strobe, unless told to ignore strobes.
  bit ignore = 1'b0, rand_busy = 1'b0;
  int bcnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      lcd_idle <= 1'b1;
      bcnt     <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) lcd_idle <= 1'b1;
    end else if (stb != 8'h00 && !ignore) begin
      lcd_idle <= 1'b0;
      bcnt     <= rand_busy ? int'($urandom_range(1, 4)) : 3;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct { int cmd; logic [7:0] ch; logic [6:0] addr; } ev_t;
  ev_t exp_q[$];
  int  mline = 0, mcol = 0;

  function automatic void push_cmd(input int c, input logic [7:0] ch, input logic [6:0] a);
    ev_t e;
    e.cmd = c; e.ch = ch; e.addr = a;
    exp_q.push_back(e);
  endfunction

  function automatic void model_char(input logic [7:0] c);
    if (mcol == LL) begin
      push_cmd(C_CURSOR, 8'h00, (mline != 0) ? 7'h00 : 7'h40);
      mline = 1 - mline;
      mcol  = 0;
    end
    push_cmd(C_WCHAR, c, 7'h00);
    mcol++;
  endfunction

  function automatic void model_init();
    exp_q.delete();
    foreach (INIT_SEQ[i]) push_cmd(INIT_SEQ[i], 8'h00, 7'h00);
  endfunction

  // Per-cycle compare: strobe legality, wr_ready rule, err stickiness, scoreboard.
  int   first_stb = -1, last_stb = -1, last_cmd = -1, err_rise = -1, ack_cnt = 0;
  logic [6:0] last_addr = 7'h7f;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    int n, idx;
    ev_t e;
    if (!rst) begin
      n = $countones(stb);
      chk("one_strobe", (n <= 1), 1);
      chk("wr_ready_rule", (wr_ready && (!init_done || clr_req)), 0);
      if (err_prev) chk("err_sticky", err, 1);
      if (err && !err_prev) err_rise = cyc;
      if (clr_ack) ack_cnt++;
      if (n == 1) begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (stb[i]) idx = i;
        chk("strobe_when_idle", lcd_idle, 1);
        if (first_stb < 0) first_stb = cyc;
        if (last_cmd == C_RESET && !init_done) chk("reset_gap", ((cyc - last_stb) >= 1 + 3 + GAP), 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got cmd %0d at cycle %0d, expected none", idx, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cmd", idx, e.cmd);
          if (e.cmd == C_WCHAR)  chk("char_data", char_data, e.ch);
          if (e.cmd == C_CURSOR) chk("cursor_addr", cursor_addr, e.addr);
        end
        if (idx == C_CURSOR) last_addr = cursor_addr;
        last_stb = cyc;
        last_cmd = idx;
      end
    end
    err_prev = err;
  end

  task automatic check_reset_vals(input string nm);
    chk({nm, "_strobes"}, stb, 0);
    chk({nm, "_char"}, char_data, 0);
    chk({nm, "_addr"}, cursor_addr, 0);
    chk({nm, "_wr_ready"}, wr_ready, 0);
    chk({nm, "_clr_ack"}, clr_ack, 0);
    chk({nm, "_init_done"}, init_done, 0);
    chk({nm, "_line"}, line, 0);
    chk({nm, "_col"}, col, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  task automatic wait_accept(input string nm);
    for (int k = 0; k < 300; k++) begin
      if (wr_ready === 1'b1) begin
        @(posedge clk); #1;
        wr_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL %s_accept: wr_ready stayed low, expected handshake", nm);
    wr_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_char  = c;
    model_char(c);
    #1;
    wait_accept("send");
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && wr_ready === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL %s_idle: %0d commands pending wr_ready %b, expected drained", nm, exp_q.size(), wr_ready);
  endtask

  task automatic wait_ack(input int a0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (ack_cnt != a0) return;
    end
  endtask

  task automatic do_clear();
    int a0;
    a0 = ack_cnt;
    @(negedge clk);
    clr_req = 1'b1;
    push_cmd(C_CLEAR, 8'h00, 7'h00);
    mline = 0; mcol = 0;
    wait_ack(a0);
    clr_req = 1'b0;
    chk("clr_ack_pulse", ack_cnt - a0, 1);
    chk("clr_col", col, 0);
    chk("clr_line", line, 0);
  endtask

  initial begin
    int a0;
    model_init();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;

    // Power-up count then abort mid-init with a one-cycle reset.
    while (cyc < 30) @(negedge clk);
    chk("first_strobe_cyc", first_stb, 21);
    rst = 1'b1;
    model_init();
    first_stb = -1;
    last_cmd  = -1;
    @(negedge clk); #1;
    check_reset_vals("mid_rst");
    rst = 1'b0;

    for (int k = 0; k < 600 && !init_done; k++) begin @(negedge clk); #1; end
    chk("init_done", init_done, 1);
    chk("restart_first_strobe_cyc", first_stb, 21);
    chk("init_last_cmd", last_cmd, C_ON);
    chk("init_all_cmds", exp_q.size(), 0);
    chk("init_after_on_done", ((cyc - last_stb) >= 4), 1);
    chk("init_line", line, 0);
    chk("init_col", col, 0);
    chk("init_err", err, 0);

    // 17 chars: wrap onto line 1.
    rand_busy = 1'b1;
    for (int i = 0; i < 17; i++) send(8'h41 + 8'(i));
    wait_idle("w17");
    chk("w17_line", line, 1);
    chk("w17_col", col, 1);
    chk("w17_cursor_addr", last_addr, 7'h40);
    chk("w17_last_cmd", last_cmd, C_WCHAR);

    // 33 chars from home: wrap back to line 0.
    do_clear();
    for (int i = 0; i < 32; i++) send(8'($urandom_range(32, 126)));
    wait_idle("w32");
    chk("w32_line", line, 1);
    chk("w32_col", col, 16);
    send(8'h7a);
    wait_idle("w33");
    chk("w33_line", line, 0);
    chk("w33_col", col, 1);
    chk("w33_cursor_addr", last_addr, 7'h00);

    // Clear and char requested together: clear wins, then the char.
    @(negedge clk);
    a0 = ack_cnt;
    clr_req = 1'b1; wr_valid = 1'b1; wr_char = 8'h5a;
    push_cmd(C_CLEAR, 8'h00, 7'h00);
    mline = 0; mcol = 0;
    model_char(8'h5a);
    #1;
    chk("clr_blocks_ready", wr_ready, 0);
    wait_ack(a0);
    chk("clr_first_col", col, 0);
    clr_req = 1'b0;
    #1;
    wait_accept("clr_char");
    wait_idle("clr_char");
    chk("clr_ack_once", ack_cnt - a0, 1);
    chk("clr_char_col", col, 1);
    chk("clr_char_line", line, 0);

    // Engine never acknowledges: timeout sets err, sequence carries on.
    ignore = 1'b1;
    send(8'h21);
    wait_idle("timeout");
    ignore = 1'b0;
    chk("timeout_err", err, 1);
    chk("timeout_delay", err_rise - last_stb, ACKTO);
    chk("timeout_col", col, 2);
    send(8'h22);
    wait_idle("post_timeout");
    chk("post_timeout_col", col, 3);
    chk("post_timeout_err", err, 1);

    // Random mix of chars and clears.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) do_clear();
      else send(8'($urandom));
    end
    wait_idle("rand");
    chk("rand_line", line, mline);
    chk("rand_col", col, mcol);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
